uart_cmd_parser: RTL
====================

// Module: uart_cmd_parser
// PURPOSE
//  Downstream consumer of the UART core's RX FIFO: pops received bytes, frames them
//  into 4-byte command packets, checks them, and presents each good command on a
//  valid/ready port to the game logic. Bad or stalled frames are dropped and counted.
//  Packet format: SYNC, OP, ARG, CHK, where CHK = SYNC ^ OP ^ ARG.
// PARAMETERS
//  SYNC_BYTE       8'hA5      frame start marker
//  TIMEOUT_CYCLES  1_000_000  max clk cycles between bytes inside a frame (10 ms @100 MHz)
//  ERR_W           8          width of saturating error counter
// PORTS
//  clk_100MHz  in   1      system clock; all logic on rising edge
//  reset       in   1      synchronous, active-low reset
//  rx_empty    in   1      RX FIFO empty flag
//  read_data   in   8      RX FIFO head byte; valid while rx_empty=0
//  read_uart   out  1      RX FIFO pop strobe; byte consumed in same cycle
//  cmd_valid   out  1      command available
//  cmd_ready   in   1      consumer accepts command when cmd_valid & cmd_ready
//  cmd_op      out  8      command opcode
//  cmd_arg     out  8      command argument
//  frame_err   out  1      1-cycle pulse on dropped frame (checksum or timeout)
//  err_count   out  ERR_W  dropped-frame count, saturates at all-ones
// BEHAVIOUR
//  Reset (reset=0 at clk edge): state=HUNT; read_uart, cmd_valid, frame_err = 0;
//   cmd_op, cmd_arg, err_count = 0; timeout counter cleared; partial frame discarded.
//  Pop rule: read_uart = (state in HUNT/GET_OP/GET_ARG/GET_CHK) & ~rx_empty & ~pop_d.
//   pop_d is read_uart registered, so at most one pop every 2 cycles.
//   This lets the FIFO empty flag settle after each pop.
//   The byte is sampled from read_data in the cycle read_uart=1.
//  FSM (advances only on a pop cycle, except OUT and timeout):
//   HUNT:    byte==SYNC_BYTE -> GET_OP; any other byte is discarded silently, no error.
//   GET_OP:  latch op -> GET_ARG.
//   GET_ARG: latch arg -> GET_CHK.
//   GET_CHK: byte==SYNC^op^arg -> OUT, with cmd_op/cmd_arg loaded and cmd_valid=1
//            in the next cycle; else frame_err=1 for 1 cycle, err_count+=1, -> HUNT.
//   OUT:     hold cmd_valid, cmd_op, cmd_arg stable and pop nothing (back-pressure)
//            until cmd_valid&cmd_ready; then cmd_valid=0 next cycle -> HUNT.
//  Latency: good CHK pop at cycle N -> cmd_valid=1 at N+1; if cmd_ready already=1,
//   the handshake completes at N+1 and the next pop can occur at N+2.
//  cmd_op/cmd_arg keep the last accepted values after handshake; they change only on
//   a new good frame.
//  Timeout: in GET_OP/GET_ARG/GET_CHK, counter increments every cycle without a pop and
//   clears on a pop. Reaching TIMEOUT_CYCLES: frame_err pulse, err_count+=1, -> HUNT.
//   No timeout in HUNT or OUT; counter held at 0 there.
//  SYNC_BYTE received inside a frame is treated as data; no resync mid-frame.
//  err_count saturates at 2^ERR_W-1; frame_err still pulses when saturated.
//  Checksum failure and timeout cannot occur in the same cycle (a pop clears the timer).
// TESTING
//  1 FIFO preloaded A5,01,07,A3; cmd_ready=1 -> one cmd_valid pulse, op=01, arg=07,
//    err_count=0, exactly 4 pops with >=1 idle cycle between pops.
//  2 Bytes 00,FF,A5,02,10,B7 -> junk discarded silently; command op=02, arg=10;
//    frame_err never asserted.
//  3 A5,01,07,00 (bad CHK) -> frame_err 1-cycle pulse, err_count=1, no cmd_valid;
//    a following good frame is decoded normally.
//  4 Good frame with cmd_ready=0 for 50 cycles, 2nd frame queued in FIFO ->
//    cmd_valid, op, arg stable; read_uart=0 throughout; 2nd frame decoded after accept.
//  5 TIMEOUT_CYCLES=100; send A5,01 then stall -> frame_err exactly 100 cycles after
//    the last pop, state returns to HUNT, err_count=1.
//  6 reset=0 between ARG and CHK, then a new good frame -> outputs 0 during reset;
//    leftover CHK byte discarded in HUNT; new frame decoded.
//    300 bad frames with ERR_W=8 -> err_count holds at 255.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Frames bytes popped from the UART RX FIFO into SYNC/OP/ARG/CHK packets and
// presents good commands on a valid/ready port; bad or stalled frames are counted.
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter int         ERR_W          = 8
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             rx_empty,
    input  logic [7:0]       read_data,
    output logic             read_uart,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [7:0]       cmd_op,
    output logic [7:0]       cmd_arg,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_GET_OP  = 3'd1,
        S_GET_ARG = 3'd2,
        S_GET_CHK = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] s, input logic [7:0] o,
                                             input logic [7:0] a);
        return s ^ o ^ a;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_pop_d;
    logic [7:0]       r_op;
    logic [7:0]       r_arg;
    logic [CNT_W-1:0] r_to_cnt;
    logic             r_cmd_valid;
    logic [7:0]       r_cmd_op;
    logic [7:0]       r_cmd_arg;
    logic             r_frame_err;
    logic [ERR_W-1:0] r_err_count;

    logic w_in_frame;
    logic w_nxt_in_frame;
    logic w_pop;
    logic w_chk_ok;
    logic w_timeout;
    logic w_bad_chk;
    logic w_drop;
    logic w_accept;

    // The pop_d gap gives the FIFO empty flag a cycle to settle after each pop.
    assign w_in_frame     = (r_state == S_GET_OP) || (r_state == S_GET_ARG) ||
                            (r_state == S_GET_CHK);
    assign w_nxt_in_frame = (w_state_nxt == S_GET_OP) || (w_state_nxt == S_GET_ARG) ||
                            (w_state_nxt == S_GET_CHK);
    assign w_pop          = reset && (w_in_frame || (r_state == S_HUNT)) &&
                            !rx_empty && !r_pop_d;
    assign w_chk_ok       = (read_data == frame_chk(SYNC_BYTE, r_op, r_arg));
    assign w_timeout      = w_in_frame && !w_pop && (r_to_cnt >= TO_LAST);
    assign w_bad_chk      = (r_state == S_GET_CHK) && w_pop && !w_chk_ok;
    assign w_drop         = w_bad_chk || w_timeout;
    assign w_accept       = r_cmd_valid && cmd_ready;

    assign read_uart = w_pop;
    assign cmd_valid = r_cmd_valid;
    assign cmd_op    = r_cmd_op;
    assign cmd_arg   = r_cmd_arg;
    assign frame_err = r_frame_err;
    assign err_count = r_err_count;

    // State register.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a SYNC byte inside a frame is plain data.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HUNT: begin
                if (w_pop && (read_data == SYNC_BYTE)) w_state_nxt = S_GET_OP;
                else                                   w_state_nxt = S_HUNT;
            end
            S_GET_OP: begin
                if (w_pop)          w_state_nxt = S_GET_ARG;
                else if (w_timeout) w_state_nxt = S_HUNT;
                else                w_state_nxt = S_GET_OP;
            end
            S_GET_ARG: begin
                if (w_pop)          w_state_nxt = S_GET_CHK;
                else if (w_timeout) w_state_nxt = S_HUNT;
                else                w_state_nxt = S_GET_ARG;
            end
            S_GET_CHK: begin
                if (w_pop)          w_state_nxt = w_chk_ok ? S_OUT : S_HUNT;
                else if (w_timeout) w_state_nxt = S_HUNT;
                else                w_state_nxt = S_GET_CHK;
            end
            S_OUT: begin
                if (w_accept) w_state_nxt = S_HUNT;
                else          w_state_nxt = S_OUT;
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    // Datapath: byte latches, command output, timeout timer and error counter.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            r_pop_d     <= 1'b0;
            r_op        <= 8'h00;
            r_arg       <= 8'h00;
            r_to_cnt    <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= 8'h00;
            r_cmd_arg   <= 8'h00;
            r_frame_err <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_pop_d     <= w_pop;
            r_frame_err <= w_drop;
            if (w_drop && (r_err_count != {ERR_W{1'b1}})) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
            if ((r_state == S_GET_OP) && w_pop) begin
                r_op <= read_data;
            end
            if ((r_state == S_GET_ARG) && w_pop) begin
                r_arg <= read_data;
            end
            if ((r_state == S_GET_CHK) && w_pop && w_chk_ok) begin
                r_cmd_valid <= 1'b1;
                r_cmd_op    <= r_op;
                r_cmd_arg   <= r_arg;
            end else if (w_accept) begin
                r_cmd_valid <= 1'b0;
            end
            // A pop loads 1 so the drop pulse lands TIMEOUT_CYCLES cycles after it.
            if (!w_nxt_in_frame) begin
                r_to_cnt <= '0;
            end else if (w_pop) begin
                r_to_cnt <= CNT_W'(1);
            end else begin
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            end
        end
    end

endmodule
